// File: rtl/register_file_sb.sv
// Multi-read-port register file with same-cycle write bypass and a per-register
// pending scoreboard that decode reserves and writeback releases.
module register_file_sb #(
  parameter int                WIDTH     = 64,
  parameter int                DEPTH     = 32,
  parameter int                ADDR_W    = 5,
  parameter int                NUM_RD    = 2,
  parameter int                ZERO_REG  = 1,
  parameter int                BYPASS    = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     regWrite,
  input  logic [ADDR_W-1:0]        write_register,
  input  logic [WIDTH-1:0]         write_data,
  input  logic [NUM_RD*ADDR_W-1:0] read_register,
  output logic [NUM_RD*WIDTH-1:0]  read_data,
  output logic [NUM_RD-1:0]        read_pending,
  input  logic                     reserve_en,
  input  logic [ADDR_W-1:0]        reserve_register,
  output logic [ADDR_W:0]          pending_count
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pending;

  logic wr_ok;
  logic rs_ok;
  logic cnt_inc;
  logic cnt_dec;

  // Register 0 swallows writes and reservations when it is hardwired to zero.
  assign wr_ok = regWrite   && !((ZERO_REG != 0) && (write_register   == '0));
  assign rs_ok = reserve_en && !((ZERO_REG != 0) && (reserve_register == '0));

  // A reserve to the register being written keeps it pending, so the write
  // releases nothing in that case.
  assign cnt_inc = rs_ok && !pending[reserve_register];
  assign cnt_dec = wr_ok && pending[write_register] &&
                   !(rs_ok && (reserve_register == write_register));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= RESET_VAL;
      end
      if (ZERO_REG != 0) begin
        regs[0] <= '0;
      end
      pending       <= '0;
      pending_count <= '0;
    end else begin
      if (wr_ok) begin
        regs[write_register]    <= write_data;
        pending[write_register] <= 1'b0;
      end
      if (rs_ok) begin
        pending[reserve_register] <= 1'b1;
      end
      pending_count <= pending_count + {{ADDR_W{1'b0}}, cnt_inc}
                                     - {{ADDR_W{1'b0}}, cnt_dec};
    end
  end

  always_comb begin
    read_data    = '0;
    read_pending = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      logic [ADDR_W-1:0] ra;
      logic              byp_hit;
      ra      = read_register[p*ADDR_W +: ADDR_W];
      byp_hit = (BYPASS != 0) && regWrite && (write_register == ra);
      if ((ZERO_REG != 0) && (ra == '0)) begin
        read_data[p*WIDTH +: WIDTH] = '0;
        read_pending[p]             = 1'b0;
      end else if (byp_hit) begin
        read_data[p*WIDTH +: WIDTH] = write_data;
        read_pending[p]             = 1'b0;
      end else begin
        read_data[p*WIDTH +: WIDTH] = regs[ra];
        read_pending[p]             = pending[ra];
      end
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: one bypassing and one non-bypassing
// instance share stimulus and are checked against an array-based model.
module tb_register_file_sb;

  localparam logic [63:0] RV = 64'h5;

  logic        clk;
  logic        rst;
  logic        regWrite;
  logic [4:0]  write_register;
  logic [63:0] write_data;
  logic [4:0]  rd0, rd1;
  logic [9:0]  read_register;
  logic        reserve_en;
  logic [4:0]  reserve_register;

  logic [127:0] rdata_b, rdata_n;
  logic [1:0]   rpend_b, rpend_n;
  logic [5:0]   cnt_b, cnt_n;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  assign read_register = {rd1, rd0};

  register_file_sb #(.RESET_VAL(RV), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .regWrite(regWrite), .write_register(write_register),
    .write_data(write_data), .read_register(read_register), .read_data(rdata_b),
    .read_pending(rpend_b), .reserve_en(reserve_en),
    .reserve_register(reserve_register), .pending_count(cnt_b));

  register_file_sb #(.RESET_VAL(RV), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .regWrite(regWrite), .write_register(write_register),
    .write_data(write_data), .read_register(read_register), .read_data(rdata_n),
    .read_pending(rpend_n), .reserve_en(reserve_en),
    .reserve_register(reserve_register), .pending_count(cnt_n));

  initial clk = 0;
  always #5 clk = ~clk;

  // Model: stored values and pending flags as plain arrays.
  logic [63:0] m_mem [32];
  bit          m_pend [32];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = (i == 0) ? 64'h0 : RV;
        m_pend[i] = 0;
      end
    end else begin
      if (regWrite && write_register != 0) begin
        m_mem[write_register]  = write_data;
        m_pend[write_register] = 0;
      end
      if (reserve_en && reserve_register != 0) m_pend[reserve_register] = 1;
    end
  end

  function automatic logic [63:0] exp_data(input logic [4:0] a, input bit byp);
    if (a == 0) return 64'h0;
    if (byp && regWrite && write_register == a) return write_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_pend(input logic [4:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && regWrite && write_register == a) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic int exp_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += m_pend[i];
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("b_data0", rdata_b[63:0],   exp_data(rd0, 1));
      check("b_data1", rdata_b[127:64], exp_data(rd1, 1));
      check("b_pend0", {63'h0, rpend_b[0]}, {63'h0, exp_pend(rd0, 1)});
      check("b_pend1", {63'h0, rpend_b[1]}, {63'h0, exp_pend(rd1, 1)});
      check("n_data0", rdata_n[63:0],   exp_data(rd0, 0));
      check("n_data1", rdata_n[127:64], exp_data(rd1, 0));
      check("n_pend0", {63'h0, rpend_n[0]}, {63'h0, exp_pend(rd0, 0)});
      check("n_pend1", {63'h0, rpend_n[1]}, {63'h0, exp_pend(rd1, 0)});
      check("b_count", {58'h0, cnt_b}, 64'(exp_count()));
      check("n_count", {58'h0, cnt_n}, 64'(exp_count()));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 0; regWrite = 0; write_register = 0; write_data = 0;
    rd0 = 4; rd1 = 0; reserve_en = 0; reserve_register = 0;

    // Asynchronous reset between edges
    step();
    rst = 1;
    #1;
    check("rst_data_r4", rdata_b[63:0], 64'h5);
    check("rst_data_r0", rdata_b[127:64], 64'h0);
    check("rst_pend", {62'h0, rpend_b}, 64'h0);
    check("rst_count", {58'h0, cnt_b}, 64'h0);
    chk_en = 1;
    step();
    rst = 0;

    // Write r7, then read on both ports
    regWrite = 1; write_register = 7; write_data = 64'hDEAD_BEEF; rd0 = 9; rd1 = 9;
    step();
    regWrite = 0; rd0 = 7; rd1 = 7;
    #1;
    check("r7_port0", rdata_b[63:0], 64'hDEAD_BEEF);
    check("r7_port1", rdata_b[127:64], 64'hDEAD_BEEF);
    step();
    regWrite = 1; write_register = 0; write_data = 64'h1; rd0 = 0;
    #1;
    check("r0_during_wr", rdata_b[63:0], 64'h0);
    step();
    regWrite = 0;
    #1;
    check("r0_after_wr", rdata_b[63:0], 64'h0);

    // Bypass vs. no bypass
    step();
    regWrite = 1; write_register = 3; write_data = 64'hA5; rd0 = 3; rd1 = 7;
    #1;
    check("byp_r3", rdata_b[63:0], 64'hA5);
    check("nobyp_r3", rdata_n[63:0], 64'h5);
    step();
    regWrite = 0;
    #1;
    check("r3_stored", rdata_n[63:0], 64'hA5);

    // Scoreboard reserve / release
    reserve_en = 1; reserve_register = 5; rd0 = 5;
    step();
    reserve_en = 0;
    #1;
    check("r5_pend", {63'h0, rpend_b[0]}, 64'h1);
    check("r5_count", {58'h0, cnt_b}, 64'h1);
    regWrite = 1; write_register = 5; write_data = 64'h9;
    #1;
    check("r5_byp_pend", {63'h0, rpend_b[0]}, 64'h0);
    check("r5_nobyp_pend", {63'h0, rpend_n[0]}, 64'h1);
    step();
    regWrite = 0;
    #1;
    check("r5_count_rel", {58'h0, cnt_b}, 64'h0);

    // Same-cycle reserve and write of a pending register
    reserve_en = 1; reserve_register = 9; rd1 = 9;
    step();
    regWrite = 1; write_register = 9; write_data = 64'h77;
    step();
    regWrite = 0; reserve_en = 0;
    #1;
    check("r9_data", rdata_b[127:64], 64'h77);
    check("r9_pend", {63'h0, rpend_b[1]}, 64'h1);
    check("r9_count", {58'h0, cnt_b}, 64'h1);
    reserve_en = 1; reserve_register = 0;
    step();
    reserve_en = 0;
    #1;
    check("r0_reserve", {58'h0, cnt_b}, 64'h1);

    // Release r9 while reserving r1, then r2, r3; reset mid-operation
    regWrite = 1; write_register = 9; write_data = 64'h11;
    reserve_en = 1; reserve_register = 1; rd0 = 1; rd1 = 2;
    step();
    regWrite = 0; reserve_register = 2;
    step();
    reserve_register = 3;
    step();
    reserve_en = 0;
    #1;
    check("three_pending", {58'h0, cnt_b}, 64'h3);
    check("r2_pending", {63'h0, rpend_n[1]}, 64'h1);
    rst = 1; regWrite = 1; write_register = 12; write_data = 64'hBAD;
    #1;
    check("midrst_count", {58'h0, cnt_b}, 64'h0);
    check("midrst_pend", {62'h0, rpend_n}, 64'h0);
    step();
    rst = 0; regWrite = 0; rd0 = 12; rd1 = 7;
    #1;
    check("rst_wr_dropped", rdata_b[63:0], 64'h5);
    check("r7_reset", rdata_b[127:64], 64'h5);

    // A few more writes checked only by the model
    for (int i = 1; i < 6; i++) begin
      regWrite = 1; write_register = 5'(i * 5); write_data = 64'(i) * 64'h1111;
      reserve_en = 1; reserve_register = 5'(i * 3); rd0 = 5'(i * 5); rd1 = 5'(i * 3);
      step();
    end
    regWrite = 0; reserve_en = 0;
    step();
    step();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
